acq_sequencer: RTL and testbench

Acquisition controller in the clklvds domain that sequences writes of the 140-bit LVDS sample word into the capture FIFO.
- Armed by a command pulse, it waits out a holdoff.
- It then detects a trigger: rising threshold crossing on a selected lane, a force pulse, or an auto-timeout.
- After the trigger it writes exactly `length` words into the FIFO, throttled by FIFO fill level, then reports done.
- Command-side configuration arrives already synchronised into clklvds.

---
 rtl/acq_sequencer_pkg.sv | 26 ++
 rtl/acq_trigger_detect.sv | 75 +++++++
 rtl/acq_sequencer.sv | 163 ++++++++++++++++
 tb/tb_acq_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_sequencer_pkg.sv
// Shared types and constants for the LVDS acquisition sequencer.
// The lane geometry constants are also used by the command processor.
package acq_sequencer_pkg;

  localparam int NLANES  = 14;
  localparam int SW      = 10;
  localparam int LENW    = 16;
  localparam int TOW     = 24;
  localparam int FIFO_HW = 1020;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } acq_state_t;

  typedef enum logic [1:0] {
    TRIG_NONE    = 2'd0,
    TRIG_THRESH  = 2'd1,
    TRIG_FORCE   = 2'd2,
    TRIG_TIMEOUT = 2'd3
  } trig_src_t;

endpackage

// File: rtl/acq_trigger_detect.sv
// Trigger detection: lane select, previous-sample register, threshold crossing,
// auto-trigger timeout and priority encoding (force > threshold > timeout).
module acq_trigger_detect
  import acq_sequencer_pkg::*;
#(
  parameter int NLANES = acq_sequencer_pkg::NLANES,
  parameter int SW     = acq_sequencer_pkg::SW,
  parameter int TOW    = acq_sequencer_pkg::TOW
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_wait,
  input  logic                 i_force,
  input  logic [NLANES*SW-1:0] i_lvds_bits,
  input  logic [3:0]           i_lane,
  input  logic [SW-1:0]        i_threshold,
  input  logic                 i_trig_en,
  input  logic [TOW-1:0]       i_timeout,
  output logic                 o_fire,
  output trig_src_t            o_src
);

  logic [SW-1:0]  w_lanes [NLANES];
  logic           w_lane_ok;
  logic [SW-1:0]  w_cur;
  logic           w_thr_hit;
  logic           w_to_hit;
  logic [SW-1:0]  r_prev;
  logic [TOW-1:0] r_to_cnt;

  generate
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      assign w_lanes[gi] = i_lvds_bits[gi*SW +: SW];
    end
  endgenerate

  // Lanes beyond the word width read as zero and never fire the threshold.
  assign w_lane_ok = (int'(i_lane) < NLANES);
  assign w_cur     = w_lane_ok ? w_lanes[i_lane] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev   <= '0;
      r_to_cnt <= '0;
    end else begin
      r_prev <= w_cur;
      if (!i_in_wait) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != '1) begin
        r_to_cnt <= r_to_cnt + TOW'(1);
      end
    end
  end

  assign w_thr_hit = i_trig_en && w_lane_ok && (r_prev < i_threshold) && (w_cur >= i_threshold);
  assign w_to_hit  = (i_timeout != '0) && (r_to_cnt == i_timeout);

  always_comb begin
    o_fire = 1'b0;
    o_src  = TRIG_NONE;
    if (i_in_wait) begin
      if (i_force) begin
        o_fire = 1'b1;
        o_src  = TRIG_FORCE;
      end else if (w_thr_hit) begin
        o_fire = 1'b1;
        o_src  = TRIG_THRESH;
      end else if (w_to_hit) begin
        o_fire = 1'b1;
        o_src  = TRIG_TIMEOUT;
      end
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arm -> holdoff -> trigger -> post-trigger FIFO writes -> done.
// All logic runs on clklvds; cfg inputs are already synchronous to it.
module acq_sequencer
  import acq_sequencer_pkg::*;
#(
  parameter int NLANES  = acq_sequencer_pkg::NLANES,
  parameter int SW      = acq_sequencer_pkg::SW,
  parameter int LENW    = acq_sequencer_pkg::LENW,
  parameter int TOW     = acq_sequencer_pkg::TOW,
  parameter int FIFO_HW = acq_sequencer_pkg::FIFO_HW
) (
  input  logic                 clklvds,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 force_trig,
  input  logic [LENW-1:0]      cfg_length,
  input  logic [LENW-1:0]      cfg_holdoff,
  input  logic [SW-1:0]        cfg_threshold,
  input  logic [3:0]           cfg_lane,
  input  logic                 cfg_trig_en,
  input  logic [TOW-1:0]       cfg_timeout,
  input  logic [NLANES*SW-1:0] lvds_bits,
  input  logic [10:0]          fifo_wrused,
  input  logic                 fifo_wrfull,
  output logic                 fifo_wr,
  output logic [NLANES*SW-1:0] fifo_data,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           trig_src,
  output logic                 overflow,
  output logic [LENW-1:0]      words_written
);

  acq_state_t           r_state;
  acq_state_t           w_state_next;
  logic                 w_latch;
  logic                 w_write;
  logic                 w_fire;
  trig_src_t            w_src;
  logic [LENW-1:0]      w_words_inc;

  logic [LENW-1:0]      r_cfg_length;
  logic [LENW-1:0]      r_cfg_holdoff;
  logic [SW-1:0]        r_cfg_threshold;
  logic [3:0]           r_cfg_lane;
  logic                 r_cfg_trig_en;
  logic [TOW-1:0]       r_cfg_timeout;
  logic [LENW-1:0]      r_hold_cnt;
  logic [LENW-1:0]      r_words;
  trig_src_t            r_trig_src;
  logic                 r_overflow;
  logic                 r_fifo_wr;
  logic [NLANES*SW-1:0] r_fifo_data;

  acq_trigger_detect #(
    .NLANES (NLANES),
    .SW     (SW),
    .TOW    (TOW)
  ) u_trig (
    .i_clk       (clklvds),
    .i_rst       (rst),
    .i_in_wait   (r_state == ST_WAIT_TRIG),
    .i_force     (force_trig),
    .i_lvds_bits (lvds_bits),
    .i_lane      (r_cfg_lane),
    .i_threshold (r_cfg_threshold),
    .i_trig_en   (r_cfg_trig_en),
    .i_timeout   (r_cfg_timeout),
    .o_fire      (w_fire),
    .o_src       (w_src)
  );

  assign w_words_inc = r_words + LENW'(1);

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_write      = 1'b0;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            w_latch      = 1'b1;
            w_state_next = ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold_cnt == r_cfg_holdoff) w_state_next = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (w_fire) w_state_next = (r_cfg_length == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: begin
          // The write that completes the run also moves to DONE on the same edge.
          if (r_words == r_cfg_length) begin
            w_state_next = ST_DONE;
          end else if (fifo_wrused < 11'(FIFO_HW)) begin
            w_write = 1'b1;
            if (w_words_inc == r_cfg_length) w_state_next = ST_DONE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clklvds or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_cfg_length    <= '0;
      r_cfg_holdoff   <= '0;
      r_cfg_threshold <= '0;
      r_cfg_lane      <= '0;
      r_cfg_trig_en   <= 1'b0;
      r_cfg_timeout   <= '0;
      r_hold_cnt      <= '0;
      r_words         <= '0;
      r_trig_src      <= TRIG_NONE;
      r_overflow      <= 1'b0;
      r_fifo_wr       <= 1'b0;
      r_fifo_data     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_fifo_wr <= w_write;
      if (w_write) begin
        r_fifo_data <= lvds_bits;
        r_words     <= w_words_inc;
      end
      if (w_latch) begin
        r_cfg_length    <= cfg_length;
        r_cfg_holdoff   <= cfg_holdoff;
        r_cfg_threshold <= cfg_threshold;
        r_cfg_lane      <= cfg_lane;
        r_cfg_trig_en   <= cfg_trig_en;
        r_cfg_timeout   <= cfg_timeout;
        r_hold_cnt      <= '0;
        r_words         <= '0;
        r_trig_src      <= TRIG_NONE;
        r_overflow      <= 1'b0;
      end else if (r_fifo_wr && fifo_wrfull) begin
        r_overflow <= 1'b1;
      end
      if (!abort && r_state == ST_HOLDOFF && r_hold_cnt != r_cfg_holdoff) begin
        r_hold_cnt <= r_hold_cnt + LENW'(1);
      end
      if (!abort && r_state == ST_WAIT_TRIG && w_fire) begin
        r_trig_src <= w_src;
      end
    end
  end

  assign fifo_wr       = r_fifo_wr;
  assign fifo_data     = r_fifo_data;
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done          = (r_state == ST_DONE);
  assign trig_src      = r_trig_src;
  assign overflow      = r_overflow;
  assign words_written = r_words;

endmodule

// File: tb/tb_acq_sequencer.sv
// Randomised and directed runs of acq_sequencer checked against a run-level
// reference model that derives trigger edge and write list from the input trace.
module tb_acq_sequencer;

  localparam int NL   = 14;
  localparam int SW   = 10;
  localparam int LENW = 16;
  localparam int TOW  = 24;
  localparam int HW   = 1020;
  localparam int W    = NL * SW;
  localparam int MAXC = 320;

  logic            clk = 1'b0;
  logic            rst;
  logic            arm, abort, force_trig;
  logic [LENW-1:0] cfg_length, cfg_holdoff;
  logic [SW-1:0]   cfg_threshold;
  logic [3:0]      cfg_lane;
  logic            cfg_trig_en;
  logic [TOW-1:0]  cfg_timeout;
  logic [W-1:0]    lvds_bits;
  logic [10:0]     fifo_wrused;
  logic            fifo_wrfull;
  logic            fifo_wr;
  logic [W-1:0]    fifo_data;
  logic            busy, done, overflow;
  logic [1:0]      trig_src;
  logic [LENW-1:0] words_written;

  always #5 clk = ~clk;

  acq_sequencer dut (
    .clklvds       (clk),
    .rst           (rst),
    .arm           (arm),
    .abort         (abort),
    .force_trig    (force_trig),
    .cfg_length    (cfg_length),
    .cfg_holdoff   (cfg_holdoff),
    .cfg_threshold (cfg_threshold),
    .cfg_lane      (cfg_lane),
    .cfg_trig_en   (cfg_trig_en),
    .cfg_timeout   (cfg_timeout),
    .lvds_bits     (lvds_bits),
    .fifo_wrused   (fifo_wrused),
    .fifo_wrfull   (fifo_wrfull),
    .fifo_wr       (fifo_wr),
    .fifo_data     (fifo_data),
    .busy          (busy),
    .done          (done),
    .trig_src      (trig_src),
    .overflow      (overflow),
    .words_written (words_written)
  );

  // Per-edge stimulus trace for one run; index = edge number, 0 is the arm edge.
  logic [W-1:0] word_a  [MAXC];
  logic [SW-1:0] s_a    [MAXC];
  logic [10:0]  used_a  [MAXC];
  bit           force_a [MAXC];
  bit           full_a  [MAXC];
  bit           abort_a [MAXC];

  int c_len, c_hold, c_thr, c_lane, c_en, c_to, ncyc;
  int m_t, m_src, m_b, m_words;
  bit m_busy, m_done, m_ovf;
  int m_wr_edges[$];
  int p_src = 0, p_words = 0;
  bit p_ovf = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic fill_default();
    for (int c = 0; c < MAXC; c++) begin
      word_a[c]  = rand_word();
      s_a[c]     = SW'($urandom_range(0, 1023));
      used_a[c]  = 11'($urandom_range(0, HW - 1));
      force_a[c] = 1'b0;
      full_a[c]  = 1'b0;
      abort_a[c] = 1'b0;
    end
  endtask

  task automatic place_samples();
    int l;
    l = (c_lane < NL) ? c_lane : NL - 1;
    for (int c = 0; c < MAXC; c++) word_a[c][SW*l +: SW] = s_a[c];
  endtask

  // Run-level model: first trigger edge by priority, then the first c_len
  // non-stalled edges after it, all cut short by the first abort edge.
  task automatic model();
    int e, cnt;
    bit reached;
    m_wr_edges.delete();
    m_t = -1;
    m_src = 0;
    m_b = ncyc;
    for (int k = 0; k < ncyc; k++) if (abort_a[k]) begin m_b = k; break; end
    if (m_b == 0) begin
      m_busy = 0; m_done = 0; m_src = p_src; m_words = p_words; m_ovf = p_ovf;
      return;
    end
    e = 2 + c_hold;
    for (int k = e; k < m_b && m_t < 0; k++) begin
      if (force_a[k]) begin
        m_t = k; m_src = 2;
      end else if (c_en != 0 && c_lane < NL && int'(s_a[k-1]) < c_thr && int'(s_a[k]) >= c_thr) begin
        m_t = k; m_src = 1;
      end else if (c_to != 0 && k - e == c_to) begin
        m_t = k; m_src = 3;
      end
    end
    cnt = 0;
    if (m_t >= 0)
      for (int k = m_t + 1; k < m_b && cnt < c_len; k++)
        if (int'(used_a[k]) < HW) begin m_wr_edges.push_back(k); cnt++; end
    m_words = cnt;
    m_ovf = 0;
    foreach (m_wr_edges[i]) if (m_wr_edges[i] + 1 < ncyc && full_a[m_wr_edges[i] + 1]) m_ovf = 1;
    reached = (m_t >= 0) && (cnt == c_len);
    if (m_b < ncyc) begin
      m_busy = 0; m_done = 0;
    end else begin
      m_busy = !reached; m_done = reached;
    end
  endtask

  task automatic run_case(input string name);
    int o_edges[$];
    logic [W-1:0] o_data[$];
    int t_obs, n;
    model();
    cfg_length    = LENW'(c_len);
    cfg_holdoff   = LENW'(c_hold);
    cfg_threshold = SW'(c_thr);
    cfg_lane      = 4'(c_lane);
    cfg_trig_en   = (c_en != 0);
    cfg_timeout   = TOW'(c_to);
    t_obs = -1;
    for (int c = 0; c < ncyc; c++) begin
      arm         = (c == 0);
      abort       = abort_a[c];
      force_trig  = force_a[c];
      lvds_bits   = word_a[c];
      fifo_wrused = used_a[c];
      fifo_wrfull = full_a[c];
      if (c == 1) begin
        cfg_length    = LENW'($urandom);
        cfg_holdoff   = LENW'($urandom);
        cfg_threshold = SW'($urandom);
        cfg_lane      = 4'($urandom);
        cfg_trig_en   = 1'($urandom);
        cfg_timeout   = TOW'($urandom_range(1, 3));
      end
      @(posedge clk);
      #1;
      if (fifo_wr) begin o_edges.push_back(c); o_data.push_back(fifo_data); end
      if (t_obs < 0 && trig_src != 2'd0) t_obs = c;
      if (c == 0) check({name, ".busy_after_arm"}, 160'(busy), 160'(m_b != 0));
    end
    check({name, ".nwrites"}, 160'(o_edges.size()), 160'(m_wr_edges.size()));
    n = (o_edges.size() < m_wr_edges.size()) ? o_edges.size() : m_wr_edges.size();
    for (int i = 0; i < n; i++) begin
      check({name, ".wr_edge"}, 160'(o_edges[i]), 160'(m_wr_edges[i]));
      check({name, ".wr_data"}, 160'(o_data[i]), 160'(word_a[m_wr_edges[i]]));
    end
    if (m_b != 0) check({name, ".trig_edge"}, 160'(t_obs), 160'(m_t));
    check({name, ".trig_src"}, 160'(trig_src), 160'(m_src));
    check({name, ".words"}, 160'(words_written), 160'(m_words));
    check({name, ".done"}, 160'(done), 160'(m_done));
    check({name, ".busy"}, 160'(busy), 160'(m_busy));
    check({name, ".overflow"}, 160'(overflow), 160'(m_ovf));
    $display("run %-8s len=%0d hold=%0d lane=%0d en=%0d to=%0d trig_edge=%0d src=%0d writes=%0d/%0d",
             name, c_len, c_hold, c_lane, c_en, c_to, t_obs, trig_src, o_edges.size(), m_wr_edges.size());
    p_src = m_src; p_words = m_words; p_ovf = m_ovf;
    arm = 0; force_trig = 0; fifo_wrfull = 0; abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
  endtask

  initial begin
    int w3;
    bit seen;
    rst = 1; arm = 0; abort = 0; force_trig = 0;
    cfg_length = '0; cfg_holdoff = '0; cfg_threshold = '0; cfg_lane = '0;
    cfg_trig_en = 0; cfg_timeout = '0; lvds_bits = '0; fifo_wrused = '0; fifo_wrfull = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.fifo_wr", 160'(fifo_wr), 160'(0));
    check("reset.busy", 160'(busy), 160'(0));
    check("reset.done", 160'(done), 160'(0));
    check("reset.trig_src", 160'(trig_src), 160'(0));
    check("reset.words", 160'(words_written), 160'(0));
    rst = 0;
    @(posedge clk);
    #1;

    // Baseline threshold crossing on a ramp
    fill_default();
    c_len = 8; c_hold = 0; c_en = 1; c_thr = 512; c_lane = 3; c_to = 0; ncyc = 40;
    for (int c = 0; c < MAXC; c++) s_a[c] = SW'(500 + 4 * (c < 100 ? c : 100));
    place_samples();
    run_case("baseline");

    // Force during holdoff is ignored, force in wait triggers
    fill_default();
    c_len = 4; c_hold = 5; c_en = 0; c_thr = 0; c_lane = 0; c_to = 0; ncyc = 30;
    force_a[3] = 1; force_a[11] = 1;
    place_samples();
    run_case("force");

    // Auto-trigger after timeout
    fill_default();
    c_len = 3; c_hold = 2; c_en = 0; c_thr = 300; c_lane = 5; c_to = 100; ncyc = 130;
    place_samples();
    run_case("auto");

    // FIFO-level stall with boundary at HW-1
    fill_default();
    c_len = 10; c_hold = 0; c_en = 0; c_thr = 0; c_lane = 1; c_to = 0; ncyc = 40;
    force_a[2] = 1;
    for (int c = 5; c < 10; c++) used_a[c] = 11'(HW);
    used_a[12] = 11'(HW - 1);
    place_samples();
    run_case("stall");

    // Abort on the cycle the third write is visible
    fill_default();
    c_len = 16; c_hold = 1; c_en = 0; c_thr = 0; c_lane = 2; c_to = 0; ncyc = 40;
    force_a[3] = 1;
    place_samples();
    model();
    w3 = m_wr_edges[2];
    abort_a[w3 + 1] = 1;
    run_case("abort");
    check("abort.words_eq3", 160'(words_written), 160'(3));

    // Clean restart after abort
    fill_default();
    c_len = 8; c_hold = 0; c_en = 1; c_thr = 512; c_lane = 3; c_to = 0; ncyc = 40;
    for (int c = 0; c < MAXC; c++) s_a[c] = SW'(500 + 4 * (c < 100 ? c : 100));
    place_samples();
    run_case("restart");

    // Zero length: done with no writes
    fill_default();
    c_len = 0; c_hold = 3; c_en = 0; c_thr = 0; c_lane = 0; c_to = 0; ncyc = 20;
    force_a[6] = 1;
    place_samples();
    run_case("len0");

    // Arm and abort in the same cycle
    fill_default();
    c_len = 4; c_hold = 0; c_en = 0; c_thr = 0; c_lane = 0; c_to = 0; ncyc = 20;
    abort_a[0] = 1; force_a[2] = 1; force_a[3] = 1;
    place_samples();
    run_case("armabrt");

    // Write while FIFO reports full sets sticky overflow
    fill_default();
    c_len = 5; c_hold = 0; c_en = 0; c_thr = 0; c_lane = 0; c_to = 0; ncyc = 20;
    force_a[2] = 1; full_a[5] = 1;
    place_samples();
    run_case("ovf");

    for (int r = 0; r < 10; r++) begin
      fill_default();
      c_len = $urandom_range(0, 12); c_hold = $urandom_range(0, 10);
      c_en = $urandom_range(0, 1); c_thr = $urandom_range(1, 1023);
      c_lane = $urandom_range(0, 15);
      c_to = ($urandom_range(0, 1) != 0) ? $urandom_range(5, 60) : 0;
      ncyc = 120;
      for (int c = 0; c < MAXC; c++) begin
        force_a[c] = ($urandom_range(0, 39) == 0);
        used_a[c]  = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(HW, 2047)) : 11'($urandom_range(1000, HW - 1));
        full_a[c]  = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 3) == 0) abort_a[$urandom_range(1, 100)] = 1;
      place_samples();
      run_case("random");
    end

    // Asynchronous reset in the middle of POST
    cfg_length = 16; cfg_holdoff = 0; cfg_trig_en = 0; cfg_timeout = 0; cfg_lane = 0;
    fifo_wrused = 11'd10; fifo_wrfull = 0;
    arm = 1;
    @(posedge clk);
    #1;
    arm = 0; force_trig = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      lvds_bits = rand_word();
      @(posedge clk);
      #1;
      if (fifo_wr) seen = 1;
    end
    force_trig = 0;
    check("arst.wr_seen", 160'(seen), 160'(1));
    #2 rst = 1;
    #1;
    check("arst.fifo_wr", 160'(fifo_wr), 160'(0));
    check("arst.fifo_data", 160'(fifo_data), 160'(0));
    check("arst.busy", 160'(busy), 160'(0));
    check("arst.trig_src", 160'(trig_src), 160'(0));
    check("arst.words", 160'(words_written), 160'(0));
    #2 rst = 0;
    @(posedge clk);
    #1;
    check("arst.idle_after", 160'(busy), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
